// File: rtl/psum_regfile.sv
// Partial-sum register file: one combinational read and one clocked write per cycle
// for the MAC accumulate port, with CLEAR and DRAIN sequencing.
module psum_regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mac_addr,
    input  logic              mac_read,
    input  logic              mac_write,
    input  logic [DATA_W-1:0] mac_wdata,
    output logic [DATA_W-1:0] mac_rdata,
    input  logic              clear_start,
    input  logic              drain_start,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DRAIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_addr_ok;
    logic              w_wr_ok;
    logic              w_ptr_last;

    // One extra bit keeps the range test correct when DEPTH == 2**ADDR_W.
    assign w_addr_ok  = ({1'b0, mac_addr} < DEPTH_EXT);
    assign w_wr_ok    = mac_write && w_addr_ok && (r_state == S_IDLE);
    assign w_ptr_last = (r_ptr == LAST_ADDR);

    // Read sees the pre-edge contents, so a same-cycle write returns the old value.
    assign mac_rdata = (mac_read && w_addr_ok) ? r_mem[mac_addr] : '0;

    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DRAIN);
    assign out_last  = (r_state == S_DRAIN) && w_ptr_last;
    assign out_data  = r_mem[r_ptr];
    assign done      = r_done;
    assign err       = r_err;

    // Single write port: MAC writes only land in IDLE, CLEAR zeroes only outside IDLE.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[mac_addr] <= mac_wdata;
        end else if ((r_state == S_CLEAR) && !reset) begin
            r_mem[r_ptr] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (mac_write && !w_wr_ok) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (clear_start) begin
                        r_state <= S_CLEAR;
                        r_ptr   <= '0;
                    end else if (drain_start) begin
                        r_state <= S_DRAIN;
                        r_ptr   <= '0;
                    end
                end
                S_CLEAR: begin
                    // ptr parks at the last entry so out_data never indexes past the array.
                    if (w_ptr_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (w_ptr_last) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_regfile.sv
// Directed bench for psum_regfile: clear, read-modify-write, range errors, drain and abort.
module tb_psum_regfile;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 100;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] mac_addr;
    logic              mac_read;
    logic              mac_write;
    logic [DATA_W-1:0] mac_wdata;
    logic [DATA_W-1:0] mac_rdata;
    logic              clear_start;
    logic              drain_start;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              err;

    int checks = 0;
    int errors = 0;

    psum_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .mac_addr(mac_addr), .mac_read(mac_read), .mac_write(mac_write),
        .mac_wdata(mac_wdata), .mac_rdata(mac_rdata),
        .clear_start(clear_start), .drain_start(drain_start),
        .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; mac_read = 1'b0; mac_write = 1'b0; mac_addr = '0; mac_wdata = '0;
        clear_start = 1'b0; drain_start = 1'b0; out_ready = 1'b0;
        tick; tick;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL reset_last got %0b exp 0", out_last); end
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
        $display("test_reset done");
    endtask

    task automatic test_clear;
        int cnt;
        int done_seen;
        clear_start = 1'b1;
        tick;
        clear_start = 1'b0;
        cnt = 0; done_seen = 0;
        while (busy === 1'b1 && cnt < 300) begin
            if (done === 1'b1) done_seen++;
            cnt++;
            tick;
        end
        checks++; if (cnt != DEPTH)    begin errors++; $display("FAIL clear_busy_cycles got %0d exp %0d", cnt, DEPTH); end
        checks++; if (done_seen != 0)  begin errors++; $display("FAIL clear_done_early got %0d exp 0", done_seen); end
        checks++; if (done !== 1'b1)   begin errors++; $display("FAIL clear_done_pulse got %0b exp 1", done); end
        tick;
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL clear_done_width got %0b exp 0", done); end
        mac_read = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            mac_addr = ADDR_W'(a);
            #1;
            checks++;
            if (mac_rdata !== 16'h0000) begin
                errors++; $display("FAIL clear_read addr %0d got %h exp 0000", a, mac_rdata);
            end
        end
        mac_read = 1'b0;
        $display("test_clear busy_cycles=%0d", cnt);
    endtask

    task automatic test_rmw;
        mac_addr = 7'd3; mac_wdata = 16'h0005; mac_write = 1'b1; mac_read = 1'b1;
        #1;
        checks++; if (mac_rdata !== 16'h0000) begin errors++; $display("FAIL rmw_same_cycle got %h exp 0000", mac_rdata); end
        tick;
        mac_write = 1'b0;
        #1;
        checks++; if (mac_rdata !== 16'h0005) begin errors++; $display("FAIL rmw_next_cycle got %h exp 0005", mac_rdata); end
        mac_addr = 7'd4; mac_wdata = 16'h8000; mac_write = 1'b1;
        tick;
        mac_write = 1'b0;
        #1;
        checks++; if (mac_rdata !== 16'h8000) begin errors++; $display("FAIL rmw_wrap got %h exp 8000", mac_rdata); end
        checks++; if (err !== 1'b0)           begin errors++; $display("FAIL rmw_err got %0b exp 0", err); end
        mac_read = 1'b0;
        $display("test_rmw done");
    endtask

    task automatic fill_mem(input logic [DATA_W-1:0] base);
        for (int i = 0; i < DEPTH; i++) begin
            mac_addr = ADDR_W'(i); mac_wdata = base + DATA_W'(i); mac_write = 1'b1;
            tick;
        end
        mac_write = 1'b0;
    endtask

    task automatic test_drain_full;
        fill_mem(16'h0000);
        out_ready = 1'b1;
        drain_start = 1'b1;
        tick;
        drain_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== DATA_W'(i) || out_last !== (i == DEPTH - 1)) begin
                errors++;
                $display("FAIL drain_beat %0d got v=%0b d=%h l=%0b exp v=1 d=%h l=%0b",
                         i, out_valid, out_data, out_last, DATA_W'(i), (i == DEPTH - 1));
            end
            tick;
        end
        checks++; if (done !== 1'b1)      begin errors++; $display("FAIL drain_done got %0b exp 1", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_end_valid got %0b exp 0", out_valid); end
        out_ready = 1'b0;
        $display("test_drain_full done");
    endtask

    task automatic test_drain_stall;
        logic [3:0] pat;
        int exp_idx;
        int cyc;
        pat = 4'b1001;
        drain_start = 1'b1;
        tick;
        drain_start = 1'b0;
        exp_idx = 0; cyc = 0;
        while (exp_idx < DEPTH && cyc < 1000) begin
            out_ready = pat[cyc % 4];
            mac_write = (cyc == 0);
            mac_addr  = 7'd50;
            mac_wdata = 16'hDEAD;
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== DATA_W'(exp_idx) || out_last !== (exp_idx == DEPTH - 1)) begin
                errors++;
                $display("FAIL stall_beat cyc %0d got v=%0b d=%h l=%0b exp v=1 d=%h l=%0b",
                         cyc, out_valid, out_data, out_last, DATA_W'(exp_idx), (exp_idx == DEPTH - 1));
            end
            if (out_ready) exp_idx++;
            tick;
            cyc++;
        end
        mac_write = 1'b0; out_ready = 1'b0;
        checks++; if (exp_idx != DEPTH) begin errors++; $display("FAIL stall_timeout got %0d exp %0d", exp_idx, DEPTH); end
        checks++; if (done !== 1'b1)    begin errors++; $display("FAIL stall_done got %0b exp 1", done); end
        checks++; if (err !== 1'b1)     begin errors++; $display("FAIL stall_err got %0b exp 1", err); end
        $display("test_drain_stall cycles=%0d", cyc);
    endtask

    task automatic test_out_of_range(input logic [ADDR_W-1:0] bad_addr);
        test_reset;
        mac_addr = bad_addr; mac_wdata = 16'hBEEF; mac_write = 1'b1; mac_read = 1'b1;
        #1;
        checks++; if (mac_rdata !== 16'h0000) begin errors++; $display("FAIL oor_read %0d got %h exp 0000", bad_addr, mac_rdata); end
        tick;
        mac_write = 1'b0;
        #1;
        checks++; if (err !== 1'b1)           begin errors++; $display("FAIL oor_err %0d got %0b exp 1", bad_addr, err); end
        checks++; if (mac_rdata !== 16'h0000) begin errors++; $display("FAIL oor_reread %0d got %h exp 0000", bad_addr, mac_rdata); end
        mac_addr = 7'd99;
        #1;
        checks++; if (mac_rdata !== 16'd99)   begin errors++; $display("FAIL oor_mem99 got %h exp 0063", mac_rdata); end
        mac_addr = 7'd0;
        #1;
        checks++; if (mac_rdata !== 16'd0)    begin errors++; $display("FAIL oor_mem0 got %h exp 0000", mac_rdata); end
        mac_read = 1'b0;
        $display("test_out_of_range addr=%0d", bad_addr);
    endtask

    task automatic test_priority_abort;
        int done_seen;
        test_reset;
        fill_mem(16'h0100);
        clear_start = 1'b1; drain_start = 1'b1;
        tick;
        clear_start = 1'b0; drain_start = 1'b0;
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL prio_busy got %0b exp 1", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL prio_valid got %0b exp 0", out_valid); end
        for (int i = 0; i < 50; i++) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", busy); end
        done_seen = 0;
        for (int i = 0; i < 120; i++) begin
            if (done === 1'b1 || busy === 1'b1) done_seen++;
            tick;
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL abort_done got %0d exp 0", done_seen); end
        mac_read = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            logic [DATA_W-1:0] exp_v;
            exp_v = (a < 50) ? 16'h0000 : (16'h0100 + DATA_W'(a));
            mac_addr = ADDR_W'(a);
            #1;
            checks++;
            if (mac_rdata !== exp_v) begin
                errors++; $display("FAIL abort_read addr %0d got %h exp %h", a, mac_rdata, exp_v);
            end
        end
        mac_read = 1'b0;
        $display("test_priority_abort done");
    endtask

    initial begin
        test_reset;
        test_clear;
        test_rmw;
        test_drain_full;
        test_drain_stall;
        test_out_of_range(7'd100);
        test_out_of_range(7'd127);
        test_priority_abort;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
